mips_exec_unit: RTL and testbench

- Execute-stage datapath slice of the multi-cycle MIPS-I bus CPU.
- Contains three parts:
  - the program-counter register;
  - the combinational ALU, which produces the result/data address, the branch decision, and the HI/LO products;
  - the branch-target adder, which computes PC+4 + (sext(imm)<<2).
- The control unit, register file, delay-slot logic and HI/LO registers sit outside and consume these outputs.

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/mips_exec_unit_if.sv | 32 +++
 rtl/mips_alu_core.sv | 101 ++++++++++
 rtl/mips_exec_unit.sv | 41 ++++
 tb/tb_mips_exec_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared opcode, funct and REGIMM encodings for the MIPS-I execute stage,
// plus the default reset vector and immediate-extension helpers.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LWL    = 6'h22;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_LWR    = 6'h26;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/mips_exec_unit_if.sv
// Instruction fields, operands and results exchanged between the control
// path (master) and the execute-stage slice (slave).
interface mips_exec_unit_if;
    logic        clk_enable;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  functcode;
    logic [4:0]  shamt;
    logic [4:0]  rt_instr;
    logic [15:0] immediate;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic [31:0] alu_result;
    logic        sig_branch;
    logic [31:0] branch_address;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output clk_enable, pc_in, opcode, functcode, shamt, rt_instr,
               immediate, rs_content, rt_content,
        input  pc_out, pc_plus4, alu_result, sig_branch, branch_address, hi, lo
    );

    modport slave (
        input  clk_enable, pc_in, opcode, functcode, shamt, rt_instr,
               immediate, rs_content, rt_content,
        output pc_out, pc_plus4, alu_result, sig_branch, branch_address, hi, lo
    );
endinterface

// File: rtl/mips_alu_core.sv
// Combinational MIPS-I ALU: result/address, branch decision and HI/LO candidates.
// Overflow never traps; every result wraps modulo 2^32.
module mips_alu_core
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  functcode,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rt_instr,
    input  logic [15:0] immediate,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] alu_result,
    output logic        sig_branch,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a, mag_b, quo_u, rem_u, quo_s, rem_s;

    assign imm_s  = sext16(immediate);
    assign imm_z  = zext16(immediate);
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'h0, rs} * {32'h0, rt};

    // Signed divide via magnitudes so the -2^31 / -1 corner is well defined.
    assign mag_a = rs[31] ? -rs : rs;
    assign mag_b = rt[31] ? -rt : rt;
    assign quo_s = (rs[31] ^ rt[31]) ? -(mag_a / mag_b) : (mag_a / mag_b);
    assign rem_s = rs[31] ? -(mag_a % mag_b) : (mag_a % mag_b);
    assign quo_u = rs / rt;
    assign rem_u = rs % rt;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        alu_result = '0;
        sig_branch = 1'b0;
        hi         = '0;
        lo         = '0;
        case (opcode)
            OP_RTYPE: begin
                case (functcode)
                    F_SLL:   alu_result = rt << shamt;
                    F_SRL:   alu_result = rt >> shamt;
                    F_SRA:   alu_result = $signed(rt) >>> shamt;
                    F_SLLV:  alu_result = rt << rs[4:0];
                    F_SRLV:  alu_result = rt >> rs[4:0];
                    F_SRAV:  alu_result = $signed(rt) >>> rs[4:0];
                    F_ADDU:  alu_result = rs + rt;
                    F_SUBU:  alu_result = rs - rt;
                    F_AND:   alu_result = rs & rt;
                    F_OR:    alu_result = rs | rt;
                    F_XOR:   alu_result = rs ^ rt;
                    F_NOR:   alu_result = ~(rs | rt);
                    F_SLT:   alu_result = {31'h0, $signed(rs) < $signed(rt)};
                    F_SLTU:  alu_result = {31'h0, rs < rt};
                    F_MULT:  {hi, lo} = prod_s;
                    F_MULTU: {hi, lo} = prod_u;
                    F_DIV: begin
                        hi = (rt == '0) ? rs : rem_s;
                        lo = (rt == '0) ? 32'hFFFF_FFFF : quo_s;
                    end
                    F_DIVU: begin
                        hi = (rt == '0) ? rs : rem_u;
                        lo = (rt == '0) ? 32'hFFFF_FFFF : quo_u;
                    end
                    F_MTHI:  hi = rs;
                    F_MTLO:  lo = rs;
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                case (rt_instr)
                    RT_BLTZ, RT_BLTZAL: sig_branch = rs[31];
                    RT_BGEZ, RT_BGEZAL: sig_branch = ~rs[31];
                    default: ;
                endcase
            end
            OP_BEQ:   sig_branch = (rs == rt);
            OP_BNE:   sig_branch = (rs != rt);
            OP_BLEZ:  sig_branch = rs[31] | (rs == '0);
            OP_BGTZ:  sig_branch = ~rs[31] & (rs != '0);
            OP_ADDIU: alu_result = rs + imm_s;
            OP_SLTI:  alu_result = {31'h0, $signed(rs) < $signed(imm_s)};
            OP_SLTIU: alu_result = {31'h0, rs < imm_s};
            OP_ANDI:  alu_result = rs & imm_z;
            OP_ORI:   alu_result = rs | imm_z;
            OP_XORI:  alu_result = rs ^ imm_z;
            OP_LUI:   alu_result = {immediate, 16'h0000};
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SW:
                      alu_result = rs + imm_s;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_exec_unit.sv
// Execute-stage slice: PC register, ALU core and branch-target adder.
// The PC is the only state element; everything else is combinational.
module mips_exec_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    mips_exec_unit_if.slave  bus
);

    logic [31:0] pc;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_VECTOR;
        else if (bus.clk_enable)
            pc <= bus.pc_in;
    end

    assign bus.pc_out         = pc;
    assign bus.pc_plus4       = pc + 32'd4;
    assign bus.branch_address = bus.pc_plus4 + {{14{bus.immediate[15]}}, bus.immediate, 2'b00};

    mips_alu_core u_alu (
        .opcode     (bus.opcode),
        .functcode  (bus.functcode),
        .shamt      (bus.shamt),
        .rt_instr   (bus.rt_instr),
        .immediate  (bus.immediate),
        .rs         (bus.rs_content),
        .rt         (bus.rt_content),
        .alu_result (bus.alu_result),
        .sig_branch (bus.sig_branch),
        .hi         (bus.hi),
        .lo         (bus.lo)
    );

endmodule

// File: tb/tb_mips_exec_unit.sv
// Self-checking bench for mips_exec_unit: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_mips_exec_unit;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] exp_pc;

    mips_exec_unit_if bus ();

    mips_exec_unit #(.RESET_VECTOR(32'hBFC0_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        br;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic [5:0] op_tab [$] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                               6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                               6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h26, 6'h28, 6'h2B};
    logic [5:0] fn_tab [$] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                               6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                               6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [4:0] ri_tab [$] = '{5'h00, 5'h01, 5'h10, 5'h11};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sa,
                         input logic [4:0] ri, input logic [15:0] imm,
                         input logic [31:0] a, input logic [31:0] b);
        bus.opcode     = op;
        bus.functcode  = fn;
        bus.shamt      = sa;
        bus.rt_instr   = ri;
        bus.immediate  = imm;
        bus.rs_content = a;
        bus.rt_content = b;
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] res, input logic br,
                             input logic [31:0] h, input logic [31:0] l);
        check({tag, "_res"}, bus.alu_result, res);
        check({tag, "_br"},  {31'h0, bus.sig_branch}, {31'h0, br});
        check({tag, "_hi"},  bus.hi, h);
        check({tag, "_lo"},  bus.lo, l);
    endtask

    // Reference model: MIPS-I semantics written with plain integer arithmetic.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [4:0] sa, input logic [4:0] ri,
                                   input logic [15:0] imm, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        int          sa_i = int'(a[4:0]);
        logic [31:0] se   = int'(shortint'(imm));
        logic [31:0] ze   = 32'(imm);
        longint      ps, qs, rs_l;
        longint unsigned pu;
        e.res = 0; e.br = 0; e.hi = 0; e.lo = 0;
        case (op)
            6'h00: case (fn)
                6'h00: e.res = b << sa;
                6'h02: e.res = b >> sa;
                6'h03: e.res = int'(b) >>> sa;
                6'h04: e.res = b << sa_i;
                6'h06: e.res = b >> sa_i;
                6'h07: e.res = int'(b) >>> sa_i;
                6'h21: e.res = a + b;
                6'h23: e.res = a - b;
                6'h24: e.res = a & b;
                6'h25: e.res = a | b;
                6'h26: e.res = a ^ b;
                6'h27: e.res = ~(a | b);
                6'h2A: e.res = (int'(a) < int'(b)) ? 1 : 0;
                6'h2B: e.res = (a < b) ? 1 : 0;
                6'h18: begin
                    ps = longint'(int'(a)) * longint'(int'(b));
                    e.hi = ps[63:32]; e.lo = ps[31:0];
                end
                6'h19: begin
                    pu = longint'(a) * longint'(b);
                    e.hi = pu[63:32]; e.lo = pu[31:0];
                end
                6'h1A: if (b == 0) begin e.hi = a; e.lo = '1; end
                       else begin
                           qs   = longint'(int'(a)) / longint'(int'(b));
                           rs_l = longint'(int'(a)) % longint'(int'(b));
                           e.lo = qs[31:0]; e.hi = rs_l[31:0];
                       end
                6'h1B: if (b == 0) begin e.hi = a; e.lo = '1; end
                       else begin e.lo = a / b; e.hi = a % b; end
                6'h11: e.hi = a;
                6'h13: e.lo = a;
                default: ;
            endcase
            6'h01: if (ri == 5'h00 || ri == 5'h10) e.br = int'(a) < 0;
                   else if (ri == 5'h01 || ri == 5'h11) e.br = int'(a) >= 0;
            6'h04: e.br = (a == b);
            6'h05: e.br = (a != b);
            6'h06: e.br = int'(a) <= 0;
            6'h07: e.br = int'(a) > 0;
            6'h09: e.res = a + se;
            6'h0A: e.res = (int'(a) < int'(se)) ? 1 : 0;
            6'h0B: e.res = (a < se) ? 1 : 0;
            6'h0C: e.res = a & ze;
            6'h0D: e.res = a | ze;
            6'h0E: e.res = a ^ ze;
            6'h0F: e.res = ze * 65536;
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2B:
                e.res = a + se;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 16));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t        e;
        logic [5:0]  op, fn;
        logic [4:0]  sa, ri;
        logic [15:0] imm;
        logic [31:0] a, b, pin;
        logic        en;

        reset = 1'b0;
        bus.clk_enable = 1'b1;
        bus.pc_in      = 32'h0000_0010;
        drive(6'h00, 6'h00, 5'd0, 5'd0, 16'h0000, 32'h0, 32'h0);

        // Asynchronous reset takes effect without a clock edge.
        #1 reset = 1'b1;
        #1 check("reset_pc", bus.pc_out, 32'hBFC0_0000);

        drive(6'h04, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h0, 32'h1);
        check("pc_plus4", bus.pc_plus4, 32'hBFC0_0004);
        check("br_addr_neg", bus.branch_address, 32'hBFC0_0000);

        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1 check("pc_load", bus.pc_out, 32'h0000_0010);
        @(negedge clk) begin bus.clk_enable = 1'b0; bus.pc_in = 32'h0000_0020; end
        @(posedge clk) #1 check("pc_hold", bus.pc_out, 32'h0000_0010);

        @(negedge clk) begin bus.clk_enable = 1'b1; reset = 1'b1; end
        #1 check("mid_reset", bus.pc_out, 32'hBFC0_0000);
        @(posedge clk) #1 check("reset_over_load", bus.pc_out, 32'hBFC0_0000);
        @(negedge clk) begin reset = 1'b0; bus.clk_enable = 1'b0; end
        exp_pc = 32'hBFC0_0000;

        drive(6'h04, 6'h00, 5'd0, 5'd0,  16'h0000, 32'h5, 32'h5);
        check_all("beq_eq", 32'h0, 1'b1, 32'h0, 32'h0);
        drive(6'h06, 6'h00, 5'd0, 5'd0,  16'h0000, 32'h0, 32'h0);
        check("blez_zero", {31'h0, bus.sig_branch}, 32'h1);
        drive(6'h07, 6'h00, 5'd0, 5'd0,  16'h0000, 32'h8000_0000, 32'h0);
        check("bgtz_neg", {31'h0, bus.sig_branch}, 32'h0);
        drive(6'h01, 6'h00, 5'd0, 5'h01, 16'h0000, 32'hFFFF_FFFF, 32'h0);
        check("bgez_neg", {31'h0, bus.sig_branch}, 32'h0);
        drive(6'h09, 6'h00, 5'd0, 5'd0,  16'h0001, 32'hFFFF_FFFF, 32'h0);
        check("addiu_wrap", bus.alu_result, 32'h0000_0000);
        drive(6'h0B, 6'h00, 5'd0, 5'd0,  16'hFFFF, 32'h1, 32'h0);
        check("sltiu_sext", bus.alu_result, 32'h0000_0001);
        drive(6'h00, 6'h03, 5'd4, 5'd0,  16'h0000, 32'h0, 32'h8000_0000);
        check("sra", bus.alu_result, 32'hF800_0000);
        drive(6'h0F, 6'h00, 5'd0, 5'd0,  16'h1234, 32'h0, 32'h0);
        check("lui", bus.alu_result, 32'h1234_0000);
        drive(6'h0D, 6'h00, 5'd0, 5'd0,  16'h8000, 32'h0, 32'h0);
        check("ori_zext", bus.alu_result, 32'h0000_8000);
        drive(6'h00, 6'h18, 5'd0, 5'd0,  16'h0000, 32'hFFFF_FFFF, 32'h2);
        check_all("mult", 32'h0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        drive(6'h00, 6'h19, 5'd0, 5'd0,  16'h0000, 32'hFFFF_FFFF, 32'h2);
        check_all("multu", 32'h0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
        drive(6'h00, 6'h1A, 5'd0, 5'd0,  16'h0000, 32'hFFFF_FFF9, 32'h2);
        check_all("div_neg", 32'h0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drive(6'h00, 6'h1B, 5'd0, 5'd0,  16'h0000, 32'h7, 32'h0);
        check_all("divu_zero", 32'h0, 1'b0, 32'h0000_0007, 32'hFFFF_FFFF);
        drive(6'h23, 6'h00, 5'd0, 5'd0,  16'hFFFC, 32'h0000_1000, 32'h0);
        check_all("lw_addr", 32'h0000_0FFC, 1'b0, 32'h0, 32'h0);
        drive(6'h03, 6'h00, 5'd0, 5'd0,  16'h0000, 32'h5, 32'h5);
        check_all("jal", 32'h0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            op  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, op_tab.size() - 1)];
            fn  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, fn_tab.size() - 1)];
            ri  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : ri_tab[$urandom_range(0, ri_tab.size() - 1)];
            sa  = 5'($urandom);
            imm = 16'($urandom);
            a   = rand_word();
            b   = ($urandom_range(0, 3) == 0) ? a : rand_word();
            en  = 1'($urandom_range(0, 1));
            pin = $urandom;
            bus.clk_enable = en;
            bus.pc_in      = pin;
            drive(op, fn, sa, ri, imm, a, b);
            e = model(op, fn, sa, ri, imm, a, b);
            check_all($sformatf("rnd%0d_op%02h_fn%02h", i, op, fn), e.res, e.br, e.hi, e.lo);
            check($sformatf("rnd%0d_br_addr", i), bus.branch_address,
                  exp_pc + 32'd4 + 32'(int'(shortint'(imm)) * 4));
            @(posedge clk) #1;
            if (en) exp_pc = pin;
            check($sformatf("rnd%0d_pc", i), bus.pc_out, exp_pc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
